// File: rtl/fmac_issue.sv
// fmac_issue: issue control for a three-stage FP multiply-accumulate pipeline.
//
// Requests are checked against the ops in S1 and S2 for register hazards and
// are then either stalled or accepted. An accepted op moves S1 -> S2 -> S3 and
// writes back from S3. A result still in S2 that comes from the FMA W path can
// be forwarded as X or Z. The module then produces the bypass and rounding
// correction controls that the datapath needs when that consumer sits in S1.
//
// Ports
//   clk, reset_n                clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake
//   req_fma                     1 = FMA op, 0 = early-result op
//   req_rs1/rs2/rs3/rd          X, Y, Z sources and destination register
//   req_frm                     rounding mode (101..111 reserved)
//   flush                       kill all in-flight ops
//   rnd_plus1, rnd_postnorm     rounding status of the op in S3
//   rn, rz, rm, rp              one-hot rounding controls for the op in S1
//   bypsel                      [0] wbypass as X, [1] wbypass as Z (S1 op)
//   bypplus1, byppostnorm       bypass correction controls (S1 op)
//   earlyressel                 S3 op takes its result from earlyres
//   wb_valid, wb_rd             writeback strobe and destination (S3 op)
//   illegal_rm                  one-cycle pulse: reserved rounding mode dropped
//   stall_cnt                   saturating count of hazard-stall cycles
module fmac_issue (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fma,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rs3,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_frm,
    input  logic        flush,
    input  logic        rnd_plus1,
    input  logic        rnd_postnorm,
    output logic        rn,
    output logic        rz,
    output logic        rm,
    output logic        rp,
    output logic [1:0]  bypsel,
    output logic        bypplus1,
    output logic        byppostnorm,
    output logic        earlyressel,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        illegal_rm,
    output logic [15:0] stall_cnt
);

    // Stage state. The rounding one-hot is kept as {rp, rm, rz, rn}.
    logic        s1_valid_q, s2_valid_q, s3_valid_q;
    logic        s1_fma_q, s2_fma_q, s3_fma_q;
    logic [4:0]  s1_rd_q, s2_rd_q, s3_rd_q;
    logic [3:0]  s1_rmode_q, rmode_d;
    logic [1:0]  s1_bypsel_q, bypsel_d;
    logic        illegal_rm_q;
    logic [15:0] stall_cnt_q;

    logic hit_s1, hit_s2_y, fwd_x, fwd_z, hit_s2_early, stall;
    logic accept, frm_reserved, issue, count_stall;

    // Hazard evaluation. Register 0 is a real FP register, so no zero exemption.
    // S3 is never checked: the register file writes before it reads.
    always_comb begin
        hit_s1       = s1_valid_q & ((req_rs1 == s1_rd_q) | (req_rs2 == s1_rd_q) |
                                     (req_rs3 == s1_rd_q));
        hit_s2_y     = s2_valid_q & (req_rs2 == s2_rd_q);  // Y has no bypass path
        fwd_x        = s2_valid_q & (req_rs1 == s2_rd_q);
        fwd_z        = s2_valid_q & (req_rs3 == s2_rd_q);
        hit_s2_early = (fwd_x | fwd_z) & ~s2_fma_q;        // early results are not forwarded
        stall        = hit_s1 | hit_s2_y | hit_s2_early;

        req_ready    = reset_n & ~stall & ~flush;
        accept       = req_valid & req_ready;
        frm_reserved = req_frm[2] & (req_frm[1] | req_frm[0]);
        issue        = accept & ~frm_reserved;
        count_stall  = req_valid & ~req_ready & ~flush;

        bypsel_d     = issue ? {fwd_z & s2_fma_q, fwd_x & s2_fma_q} : 2'b00;

        rmode_d = 4'b0000;
        if (issue) begin
            case (req_frm)
                3'b000:  rmode_d = 4'b0001;  // RNE
                3'b001:  rmode_d = 4'b0010;  // RTZ
                3'b010:  rmode_d = 4'b0100;  // RDN
                3'b011:  rmode_d = 4'b1000;  // RUP
                3'b100:  rmode_d = 4'b0001;  // RMM uses the nearest path
                default: rmode_d = 4'b0000;
            endcase
        end
    end

    // S1: control bits are zeroed whenever the stage is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_fma_q    <= 1'b0;
            s1_rd_q     <= 5'd0;
            s1_rmode_q  <= 4'b0000;
            s1_bypsel_q <= 2'b00;
        end else begin
            s1_valid_q  <= issue;
            s1_rmode_q  <= rmode_d;
            s1_bypsel_q <= bypsel_d;
            if (issue) begin
                s1_fma_q <= req_fma;
                s1_rd_q  <= req_rd;
            end
        end
    end

    // S2 and S3: payload only moves with a valid op so wb_rd holds its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_fma_q   <= 1'b0;
            s2_rd_q    <= 5'd0;
            s3_valid_q <= 1'b0;
            s3_fma_q   <= 1'b0;
            s3_rd_q    <= 5'd0;
        end else begin
            s2_valid_q <= s1_valid_q & ~flush;
            s3_valid_q <= s2_valid_q & ~flush;
            if (s1_valid_q & ~flush) begin
                s2_fma_q <= s1_fma_q;
                s2_rd_q  <= s1_rd_q;
            end
            if (s2_valid_q & ~flush) begin
                s3_fma_q <= s2_fma_q;
                s3_rd_q  <= s2_rd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_rm_q <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            illegal_rm_q <= accept & frm_reserved;
            if (count_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // A bypassed consumer in S1 always has its producer in S3 this cycle, so
    // the producer's rounding status applies directly.
    always_comb begin
        {rp, rm, rz, rn} = s1_rmode_q;
        bypsel           = s1_bypsel_q;
        bypplus1         = (|s1_bypsel_q) & rnd_plus1;
        byppostnorm      = (|s1_bypsel_q) & rnd_postnorm;
        earlyressel      = s3_valid_q & ~s3_fma_q;
        wb_valid         = s3_valid_q;
        wb_rd            = s3_rd_q;
        illegal_rm       = illegal_rm_q;
        stall_cnt        = stall_cnt_q;
    end

endmodule

// File: tb/tb_fmac_issue.sv
`timescale 1ns/1ps
module tb_fmac_issue;

    logic        clk, reset_n;
    logic        req_valid, req_ready, req_fma;
    logic [4:0]  req_rs1, req_rs2, req_rs3, req_rd;
    logic [2:0]  req_frm;
    logic        flush, rnd_plus1, rnd_postnorm;
    logic        rn, rz, rm, rp;
    logic [1:0]  bypsel;
    logic        bypplus1, byppostnorm, earlyressel, wb_valid;
    logic [4:0]  wb_rd;
    logic        illegal_rm;
    logic [15:0] stall_cnt;

    fmac_issue dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fma(req_fma),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_rd(req_rd),
        .req_frm(req_frm), .flush(flush),
        .rnd_plus1(rnd_plus1), .rnd_postnorm(rnd_postnorm),
        .rn(rn), .rz(rz), .rm(rm), .rp(rp),
        .bypsel(bypsel), .bypplus1(bypplus1), .byppostnorm(byppostnorm),
        .earlyressel(earlyressel), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .illegal_rm(illegal_rm), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: ops in flight indexed by pipeline age (1 = one cycle old).
    typedef struct {
        bit       v;
        bit       fma;
        bit [4:0] rd;
        bit [2:0] frm;
        bit [1:0] byp;
    } op_t;

    op_t       mp [1:3];
    bit [4:0]  m_wbrd;
    bit        m_ill;
    bit [15:0] m_cnt;

    typedef struct {
        bit v; bit fma; bit [4:0] rs1; bit [4:0] rs2; bit [4:0] rs3; bit [4:0] rd;
        bit [2:0] frm; bit fl; bit p1;
        bit rdy; bit [1:0] byp; bit bp1; bit early; bit wbv; bit ill; bit rn; bit [15:0] cnt;
    } tv_t;

    tv_t tv [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 3; i++) mp[i] = '{default: 0};
        m_wbrd = 5'd0;
        m_ill  = 1'b0;
        m_cnt  = 16'd0;
    endtask

    // The request must wait if any of its sources is still being computed and
    // cannot be forwarded: anything in S1, Y from S2, or X/Z from an early S2 op.
    function automatic bit m_hazard();
        bit h;
        h = 1'b0;
        if (mp[1].v && (req_rs1 == mp[1].rd || req_rs2 == mp[1].rd || req_rs3 == mp[1].rd))
            h = 1'b1;
        if (mp[2].v && req_rs2 == mp[2].rd) h = 1'b1;
        if (mp[2].v && !mp[2].fma && (req_rs1 == mp[2].rd || req_rs3 == mp[2].rd)) h = 1'b1;
        return h;
    endfunction

    function automatic logic [32:0] model_vec();
        bit r, en, nr, zr, dr, ur, bp1, bpn, early;
        bit [1:0] b;
        r   = reset_n && !flush && !m_hazard();
        en  = mp[1].v;
        nr  = en && (mp[1].frm == 3'd0 || mp[1].frm == 3'd4);
        zr  = en && mp[1].frm == 3'd1;
        dr  = en && mp[1].frm == 3'd2;
        ur  = en && mp[1].frm == 3'd3;
        b   = en ? mp[1].byp : 2'b00;
        bp1 = (b != 2'b00) && rnd_plus1;
        bpn = (b != 2'b00) && rnd_postnorm;
        early = mp[3].v && !mp[3].fma;
        return {r, nr, zr, dr, ur, b, bp1, bpn, early, mp[3].v, m_wbrd, m_ill, m_cnt};
    endfunction

    function automatic logic [32:0] dut_vec();
        return {req_ready, rn, rz, rm, rp, bypsel, bypplus1, byppostnorm, earlyressel,
                wb_valid, wb_rd, illegal_rm, stall_cnt};
    endfunction

    task automatic model_step();
        bit r, acc, legal;
        op_t n;
        r     = !flush && !m_hazard();
        acc   = req_valid && r;
        legal = (req_frm <= 3'd4);
        if (req_valid && !r && !flush && m_cnt != 16'hFFFF) m_cnt++;
        n.v      = acc && legal;
        n.fma    = req_fma;
        n.rd     = req_rd;
        n.frm    = req_frm;
        n.byp[0] = mp[2].v && mp[2].fma && req_rs1 == mp[2].rd;
        n.byp[1] = mp[2].v && mp[2].fma && req_rs3 == mp[2].rd;
        mp[3]   = mp[2];
        mp[3].v = mp[2].v && !flush;
        mp[2]   = mp[1];
        mp[2].v = mp[1].v && !flush;
        mp[1]   = n;
        if (mp[3].v) m_wbrd = mp[3].rd;
        m_ill = acc && !legal;
    endtask

    task automatic drive(input bit v, input bit fma, input bit [4:0] a, input bit [4:0] b,
                         input bit [4:0] c, input bit [4:0] d, input bit [2:0] f,
                         input bit fl, input bit p1, input bit pn);
        req_valid = v;  req_fma = fma;
        req_rs1 = a;    req_rs2 = b;   req_rs3 = c;   req_rd = d;
        req_frm = f;    flush = fl;    rnd_plus1 = p1; rnd_postnorm = pn;
    endtask

    task automatic idle();
        drive(0, 0, 31, 31, 31, 31, 0, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge clk);
        chk("cycle", {31'd0, dut_vec()}, {31'd0, model_vec()});
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {v,fma,rs1,rs2,rs3,rd,frm,flush,plus1, ready,bypsel,bypplus1,early,wbv,ill,rn,cnt}
        tv[0]  = '{1,1, 1, 2, 4, 5,0,0,0, 1,0,0,0,0,0,0,0};  // FMA producer rd=5
        tv[1]  = '{1,1, 5, 6, 5, 8,0,0,0, 0,0,0,0,0,0,1,0};  // rs1=rs3=5 vs S1: stall
        tv[2]  = '{1,1, 5, 6, 5, 8,0,0,0, 1,0,0,0,0,0,0,1};  // producer in S2: forward
        tv[3]  = '{0,0,31,31,31,31,0,0,1, 1,3,1,0,1,0,1,1};  // consumer S1, producer S3
        tv[4]  = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,0,0,0,1};
        tv[5]  = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,1,0,0,1};
        tv[6]  = '{1,0, 1, 2, 3, 7,0,0,0, 1,0,0,0,0,0,0,1};  // early op rd=7
        tv[7]  = '{1,1, 7, 2, 3, 9,0,0,0, 0,0,0,0,0,0,1,1};  // stall on S1
        tv[8]  = '{1,1, 7, 2, 3, 9,0,0,0, 0,0,0,0,0,0,0,2};  // stall on early S2
        tv[9]  = '{1,1, 7, 2, 3, 9,0,0,0, 1,0,0,1,1,0,0,3};  // early op in S3
        tv[10] = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,0,0,1,3};  // consumer S1, no bypass
        tv[11] = '{1,1, 1, 2, 4, 3,0,0,0, 1,0,0,0,0,0,0,3};  // FMA rd=3
        tv[12] = '{1,1,11,12,13,10,0,0,0, 1,0,0,0,1,0,1,3};  // independent op
        tv[13] = '{1,1,14, 3,15,16,0,0,0, 0,0,0,0,0,0,1,3};  // rs2=3 vs S2: stall
        tv[14] = '{1,1,14, 3,15,16,0,0,0, 1,0,0,0,1,0,0,4};
        tv[15] = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,1,0,1,4};
        tv[16] = '{1,1,18,19,20,17,5,0,0, 1,0,0,0,0,0,0,4};  // reserved frm accepted
        tv[17] = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,1,1,0,4};  // illegal_rm pulse
        tv[18] = '{1,1,22,23,24,21,4,0,0, 1,0,0,0,0,0,0,4};  // RMM
        tv[19] = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,0,0,1,4};  // rn for RMM
        tv[20] = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,0,0,0,4};
        tv[21] = '{0,0,31,31,31,31,0,0,0, 1,0,0,0,1,0,0,4};  // only RMM op writes back

        // Reset state, with a request present.
        model_reset();
        reset_n = 1'b0;
        drive(1, 1, 1, 2, 3, 4, 0, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {31'd0, dut_vec()}, 64'd0);
        reset_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 22; i++) begin
            drive(tv[i].v, tv[i].fma, tv[i].rs1, tv[i].rs2, tv[i].rs3, tv[i].rd,
                  tv[i].frm, tv[i].fl, tv[i].p1, 0);
            sample();
            chk($sformatf("tv%0d_ready", i), {63'd0, req_ready}, {63'd0, tv[i].rdy});
            chk($sformatf("tv%0d_bypsel", i), {62'd0, bypsel}, {62'd0, tv[i].byp});
            chk($sformatf("tv%0d_bypplus1", i), {63'd0, bypplus1}, {63'd0, tv[i].bp1});
            chk($sformatf("tv%0d_earlyressel", i), {63'd0, earlyressel}, {63'd0, tv[i].early});
            chk($sformatf("tv%0d_wb_valid", i), {63'd0, wb_valid}, {63'd0, tv[i].wbv});
            chk($sformatf("tv%0d_illegal_rm", i), {63'd0, illegal_rm}, {63'd0, tv[i].ill});
            chk($sformatf("tv%0d_rn", i), {63'd0, rn}, {63'd0, tv[i].rn});
            chk($sformatf("tv%0d_stall_cnt", i), {48'd0, stall_cnt}, {48'd0, tv[i].cnt});
            advance();
        end

        // Flush with three ops in flight.
        drive(1, 1, 20, 21, 22, 1, 1, 0, 0, 0); tick();
        drive(1, 0, 20, 21, 22, 2, 2, 0, 0, 0); tick();
        drive(1, 1, 20, 21, 22, 3, 3, 0, 0, 0); tick();
        drive(1, 1, 23, 24, 25, 4, 0, 1, 0, 0);
        sample();
        chk("flush_ready", {63'd0, req_ready}, 64'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            idle();
            sample();
            chk($sformatf("flush_wb_valid%0d", i), {63'd0, wb_valid}, 64'd0);
            if (i == 0) chk("flush_ready_after", {63'd0, req_ready}, 64'd1);
            advance();
        end

        // Randomized traffic with a small register range to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 10) < 7, $urandom % 2,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom % 6 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                  ($urandom % 20) == 0, $urandom % 2, $urandom % 2);
            tick();
        end

        // Saturation: a self-dependent early op stalls two of every three cycles.
        drive(1, 0, 9, 10, 11, 9, 0, 0, 0, 0);
        for (int i = 0; i < 99000; i++) begin
            tick();
            if (m_cnt == 16'hFFFF) break;
        end
        repeat (6) tick();
        idle();
        repeat (3) tick();
        sample();
        chk("stall_cnt_saturated", {48'd0, stall_cnt}, {48'd0, 16'hFFFF});
        advance();

        // Asynchronous reset while an op sits in S2.
        drive(1, 1, 12, 13, 14, 15, 3, 0, 1, 1); tick();
        idle(); tick();
        drive(1, 1, 16, 17, 18, 19, 0, 0, 1, 1);
        reset_n = 1'b0;
        #0.5;
        chk("async_reset", {31'd0, dut_vec()}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_in_reset", {31'd0, dut_vec()}, 64'd0);
        reset_n = 1'b1;
        idle();
        sample();
        chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
        advance();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
